// File: rtl/sra_srl_unit.sv
// -----------------------------------------------------------------------------
// sra_srl_unit
//   Multi-cycle 32-bit right shifter for the ALU shift path. It implements
//   logical (srl) and arithmetic (sra) right shifts.
//
//   The 5-bit shift amount is consumed one bit per cycle, MSB first. The
//   stages shift by 16, 8, 4, 2 and then 1, and they all reuse one 32-bit
//   accumulator. An operation takes 5 SHIFT cycles and 1 DONE cycle. The
//   next operation can be accepted one cycle after that, in IDLE.
//
// Ports
//   clock  in   1  rising-edge clock
//   reset  in   1  synchronous, active-low clear
//   start  in   1  request; sampled only while ready=1
//   in     in  32  operand, captured on the accepting edge
//   shamt  in   5  shift amount 0..31, captured on the accepting edge
//   arith  in   1  1 = sign fill (sra), 0 = zero fill (srl)
//   ready  out  1  idle and able to accept start
//   done   out  1  one-cycle pulse; out is valid in that cycle
//   out    out 32  result; held from done until the next accepted start
// -----------------------------------------------------------------------------
module sra_srl_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic        ready,
  output logic        done,
  output logic [31:0] out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_acc;
  logic [4:0]  r_amt;
  logic        r_sgn;
  logic [2:0]  r_stage;

  state_t      w_state_nxt;
  logic [31:0] w_acc_nxt;
  logic [4:0]  w_amt_nxt;
  logic        w_sgn_nxt;
  logic [2:0]  w_stage_nxt;

  // Selects the shift-amount bit that controls the current stage.
  // Stage 0 uses amt[4] (distance 16), and stage 4 uses amt[0] (distance 1).
  function automatic logic f_stage_bit(input logic [4:0] amt,
                                       input logic [2:0] stage);
    case (stage)
      3'd0:    f_stage_bit = amt[4];
      3'd1:    f_stage_bit = amt[3];
      3'd2:    f_stage_bit = amt[2];
      3'd3:    f_stage_bit = amt[1];
      default: f_stage_bit = amt[0];
    endcase
  endfunction

  // Shifts right by the fixed distance of the given stage (16 >> stage).
  // The vacated upper bits are filled with sgn.
  function automatic logic [31:0] f_shift_stage(input logic [31:0] acc,
                                                input logic [2:0]  stage,
                                                input logic        sgn);
    case (stage)
      3'd0:    f_shift_stage = {{16{sgn}}, acc[31:16]};
      3'd1:    f_shift_stage = {{8{sgn}},  acc[31:8]};
      3'd2:    f_shift_stage = {{4{sgn}},  acc[31:4]};
      3'd3:    f_shift_stage = {{2{sgn}},  acc[31:2]};
      default: f_shift_stage = {sgn,       acc[31:1]};
    endcase
  endfunction

  // State and datapath registers. Reset also clears the accumulator, so out
  // reads zero after a reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_acc   <= 32'd0;
      r_amt   <= 5'd0;
      r_sgn   <= 1'b0;
      r_stage <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_amt   <= w_amt_nxt;
      r_sgn   <= w_sgn_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  // Next-state logic and next-datapath logic.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_amt_nxt   = r_amt;
    w_sgn_nxt   = r_sgn;
    w_stage_nxt = r_stage;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_nxt   = in;
          w_amt_nxt   = shamt;
          w_sgn_nxt   = arith & in[31];
          w_stage_nxt = 3'd0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (f_stage_bit(r_amt, r_stage))
          w_acc_nxt = f_shift_stage(r_acc, r_stage, r_sgn);
        w_stage_nxt = r_stage + 3'd1;
        if (r_stage == 3'd4)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The outputs are decoded only from registers. No input reaches an output
  // without passing through a register.
  assign ready = (r_state == S_IDLE);
  assign done  = (r_state == S_DONE);
  assign out   = r_acc;

endmodule

// File: tb/tb_sra_srl_unit.sv
module tb_sra_srl_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] in;
  logic [4:0]  shamt;
  logic        arith;
  logic        ready;
  logic        done;
  logic [31:0] out;

  int n_checks = 0;
  int n_errors = 0;

  sra_srl_unit dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .in    (in),
    .shamt (shamt),
    .arith (arith),
    .ready (ready),
    .done  (done),
    .out   (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation and check the handshake and the result.
  // Checks: done arrives on E5, out is correct, and ready returns after E6.
  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [4:0] s, input logic ar,
                        input logic [31:0] exp);
    int n;
    start = 1'b1; in = a; shamt = s; arith = ar;
    tick();                                  // E0
    check({tag, "_rdy_fall"}, {31'd0, ready}, 32'd0);
    start = 1'b0; in = 32'h5A5A_A5A5; shamt = 5'd7; arith = ~ar;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 5);
    check({tag, "_out"}, out, exp);
    tick();                                  // E6
    check({tag, "_rdy_back"}, {30'd0, ready, done}, 32'd2);
  endtask

  initial begin
    int pulses;
    reset = 1'b0; start = 1'b0; in = 32'd0; shamt = 5'd0; arith = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_out",   out,            32'd0);
    reset = 1'b1;
    tick();

    // Logical and arithmetic shifts, including the boundary shift amounts
    run_op("srl31",   32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    run_op("sra31",   32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
    run_op("sra4",    32'hF0F0_F0F0, 5'd4,  1'b1, 32'hFF0F_0F0F);
    run_op("sh0",     32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF);
    run_op("srl13",   32'hDEAD_BEEF, 5'd13, 1'b0, 32'h0006_F56D);
    run_op("sra13",   32'hDEAD_BEEF, 5'd13, 1'b1, 32'hFFFE_F56D);
    run_op("sra_pos", 32'h7000_0000, 5'd3,  1'b1, 32'h0E00_0000);
    run_op("srl1",    32'h8000_0001, 5'd1,  1'b0, 32'h4000_0000);

    // Start while busy
    start = 1'b1; in = 32'h0000_FF00; shamt = 5'd8; arith = 1'b0;
    tick();                                  // E0
    start = 1'b0;
    tick();                                  // E1
    start = 1'b1; in = 32'h1234_5678; shamt = 5'd3; arith = 1'b1;
    tick();                                  // E2
    start = 1'b0;
    tick();                                  // E3
    start = 1'b1; in = 32'h8765_4321; shamt = 5'd1;
    tick();                                  // E4
    start = 1'b0;
    tick();                                  // E5
    check("busy_done", {31'd0, done}, 32'd1);
    check("busy_out",  out, 32'h0000_00FF);
    start = 1'b1; in = 32'hAAAA_0000; shamt = 5'd16; arith = 1'b0;
    tick();                                  // E6
    check("busy_once", {30'd0, ready, done}, 32'd2);
    check("busy_hold", out, 32'h0000_00FF);
    tick();                                  // E7: held start accepted
    check("busy_acc7", {31'd0, ready}, 32'd0);
    start = 1'b0;
    pulses = 0;
    while (!done && pulses < 20) begin
      tick();
      pulses++;
    end
    check("busy_lat2", pulses, 5);
    check("busy_out2", out, 32'h0000_AAAA);
    tick();

    // Reset mid-operation
    start = 1'b1; in = 32'hFFFF_0000; shamt = 5'd4; arith = 1'b1;
    tick();                                  // E0
    start = 1'b0;
    tick();                                  // E1
    tick();                                  // E2
    reset = 1'b0;
    tick();                                  // E3
    reset = 1'b1;
    check("mrst_rd",  {30'd0, ready, done}, 32'd2);
    check("mrst_out", out, 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) pulses++;
    end
    check("mrst_nodone", pulses, 0);

    // Reset and start on the same edge
    reset = 1'b0; start = 1'b1; in = 32'h8000_0000; shamt = 5'd1;
    tick();
    reset = 1'b1; start = 1'b0;
    tick();
    check("rst_start_rdy", {31'd0, ready}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) pulses++;
    end
    check("rst_start_nodone", pulses, 0);
    check("rst_start_out", out, 32'd0);

    // Result hold
    run_op("hold_op", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    for (int i = 0; i < 20; i++) begin
      in = $urandom; shamt = 5'(i); arith = i[0];
      tick();
      check("hold_out",  out, 32'h0000_0001);
      check("hold_done", {31'd0, done}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
